rank_selector: RTL and testbench

RANK_SELECTOR -- requirements
Module: rank_selector

---
 rtl/rank_selector.sv | 93 +++++++++
 tb/tb_rank_selector.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rank_selector.sv
// rank_selector: picks, from each window of N (sample, rank) pairs, the sample whose
// rank is the smallest one at or above a per-window target (largest legal rank if none).
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data/in_rank/target_rank
// form the input beat stream; out_valid/out_ready/out_data/out_rank/out_exact/out_err
// carry one result per window, held until accepted.
module rank_selector #(
  parameter int N = 7,
  parameter int DATA_W = 8,
  parameter int rank_bits = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [rank_bits-1:0] in_rank,
  input  logic [rank_bits-1:0] target_rank,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [rank_bits-1:0] out_rank,
  output logic                 out_exact,
  output logic                 out_err
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [rank_bits-1:0] NR = rank_bits'(N);
  localparam logic COLLECT = 1'b0;
  localparam logic OUTPUT = 1'b1;
  logic state;
  logic [CW-1:0] cnt;
  logic [rank_bits-1:0] tgt, t_in, t_eff, c_rank, n_rank;
  logic [DATA_W-1:0] c_data, n_data;
  logic have, have_ge, err, acc, legal, ge, take, n_have, n_ge, n_err;
  assign in_ready = rst_n && state == COLLECT;
  assign out_valid = state == OUTPUT;
  assign acc = in_valid && in_ready;
  // Beat 0 must be judged against the target arriving with it, not the stale latch.
  // A held candidate at/above target only yields to a strictly smaller rank at/above
  // target; a fallback candidate yields to any at/above-target beat or a strictly larger rank.
  always_comb begin
    t_in = target_rank == '0 ? rank_bits'(1) : (target_rank > NR ? NR : target_rank);
    t_eff = cnt == '0 ? t_in : tgt;
    legal = in_rank != '0 && in_rank <= NR;
    ge = in_rank >= t_eff;
    take = legal && (!have || (have_ge ? (ge && in_rank < c_rank) : (ge || in_rank > c_rank)));
    n_data = take ? in_data : c_data;
    n_rank = take ? in_rank : c_rank;
    n_have = have || take;
    n_ge = take ? ge : have_ge;
    n_err = err || !legal;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= COLLECT;
      cnt <= '0;
      tgt <= '0;
      have <= 1'b0;
      have_ge <= 1'b0;
      err <= 1'b0;
      c_data <= '0;
      c_rank <= '0;
      out_data <= '0;
      out_rank <= '0;
      out_exact <= 1'b0;
      out_err <= 1'b0;
    end else if (acc) begin
      if (cnt == '0) tgt <= t_in;
      if (cnt == LAST) begin
        state <= OUTPUT;
        out_data <= n_data;
        out_rank <= n_rank;
        out_exact <= n_have && n_rank == t_eff;
        out_err <= n_err;
        cnt <= '0;
        have <= 1'b0;
        have_ge <= 1'b0;
        err <= 1'b0;
        c_data <= '0;
        c_rank <= '0;
      end else begin
        cnt <= cnt + CW'(1);
        have <= n_have;
        have_ge <= n_ge;
        err <= n_err;
        c_data <= n_data;
        c_rank <= n_rank;
      end
    end else if (state == OUTPUT && out_ready) begin
      state <= COLLECT;
    end
  end
endmodule

// File: tb/tb_rank_selector.sv
// tb_rank_selector: table-driven, hand-written and randomized checks of rank_selector.
module tb_rank_selector;
  localparam int N = 7;
  typedef int arr_t[N];
  typedef struct {
    arr_t r;
    int   base;
    int   t;
    int   ed;
    int   er;
    int   ex;
    int   ee;
  } tv_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] in_rank = '0;
  logic [3:0] target_rank = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] out_data;
  logic [3:0] out_rank;
  logic out_exact;
  logic out_err;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  rank_selector #(.N(N), .DATA_W(8), .rank_bits(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rank(in_rank), .target_rank(target_rank),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rank(out_rank), .out_exact(out_exact), .out_err(out_err)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: clamp target, then search the whole window in two passes.
  task automatic model(input arr_t r, input arr_t d, input int tr, output int ed, output int er,
                       output int ex, output int ee);
    int t;
    int best;
    t = tr == 0 ? 1 : (tr > N ? N : tr);
    best = -1;
    ee = 0;
    for (int i = 0; i < N; i++) if (r[i] < 1 || r[i] > N) ee = 1;
    for (int i = 0; i < N; i++)
      if (r[i] >= 1 && r[i] <= N && r[i] >= t && (best < 0 || r[i] < r[best])) best = i;
    if (best < 0)
      for (int i = 0; i < N; i++)
        if (r[i] >= 1 && r[i] <= N && (best < 0 || r[i] > r[best])) best = i;
    ed = best < 0 ? 0 : d[best];
    er = best < 0 ? 0 : r[best];
    ex = (best >= 0 && er == t) ? 1 : 0;
  endtask
  task automatic send_beats(input arr_t r, input arr_t d, input int t, input bit gaps, input int nb);
    for (int i = 0; i < nb; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
        in_rank = 4'($urandom);
        target_rank = 4'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_rank = 4'(r[i]);
      in_data = 8'(d[i]);
      target_rank = i == 0 ? 4'(t) : 4'(t + 1 + $urandom_range(0, 14));
      chk("in_ready_collect", 32'(in_ready), 1);
      chk("no_early_valid", 32'(out_valid), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask
  task automatic check_out(input string tag, input int ed, input int er, input int ex, input int ee);
    chk({tag, "_data"}, 32'(out_data), 32'(ed));
    chk({tag, "_rank"}, 32'(out_rank), 32'(er));
    chk({tag, "_exact"}, 32'(out_exact), 32'(ex));
    chk({tag, "_err"}, 32'(out_err), 32'(ee));
  endtask
  task automatic run_window(input string tag, input arr_t r, input arr_t d, input int t, input bit gaps,
                            input int bp, input int ed, input int er, input int ex, input int ee);
    send_beats(r, d, t, gaps, N);
    chk({tag, "_latency"}, 32'(out_valid), 1);
    check_out(tag, ed, er, ex, ee);
    for (int k = 0; k < bp; k++) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_bp_valid"}, 32'(out_valid), 1);
      chk({tag, "_bp_in_ready"}, 32'(in_ready), 0);
      check_out({tag, "_bp"}, ed, er, ex, ee);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_drop_valid"}, 32'(out_valid), 0);
    chk({tag, "_ready_back"}, 32'(in_ready), 1);
    out_ready = 1'b0;
  endtask
  tv_t tbl[8];
  initial begin
    arr_t d;
    arr_t r;
    int t, ed, er, ex, ee;
    tbl[0] = '{r: '{3, 7, 4, 1, 6, 2, 5}, base: 10, t: 4, ed: 12, er: 4, ex: 1, ee: 0};
    tbl[1] = '{r: '{5, 5, 6, 1, 2, 3, 7}, base: 20, t: 4, ed: 20, er: 5, ex: 0, ee: 0};
    tbl[2] = '{r: '{1, 2, 3, 3, 2, 1, 1}, base: 30, t: 7, ed: 32, er: 3, ex: 0, ee: 0};
    tbl[3] = '{r: '{0, 9, 3, 2, 9, 0, 5}, base: 40, t: 2, ed: 43, er: 2, ex: 1, ee: 1};
    tbl[4] = '{r: '{0, 0, 0, 0, 0, 0, 0}, base: 50, t: 3, ed: 0, er: 0, ex: 0, ee: 1};
    tbl[5] = '{r: '{4, 2, 1, 3, 1, 5, 6}, base: 60, t: 0, ed: 62, er: 1, ex: 1, ee: 0};
    tbl[6] = '{r: '{2, 6, 4, 6, 1, 3, 5}, base: 70, t: 12, ed: 71, er: 6, ex: 0, ee: 0};
    tbl[7] = '{r: '{8, 15, 5, 7, 6, 8, 2}, base: 80, t: 5, ed: 82, er: 5, ex: 1, ee: 1};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    check_out("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    #1 chk("rst_release_ready", 32'(in_ready), 1);
    @(negedge clk);
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) d[i] = tbl[v].base + i;
      run_window($sformatf("tbl%0d", v), tbl[v].r, d, tbl[v].t, 1'b0, 0,
                 tbl[v].ed, tbl[v].er, tbl[v].ex, tbl[v].ee);
    end
    for (int i = 0; i < N; i++) d[i] = tbl[0].base + i;
    run_window("gaps_bp", tbl[0].r, d, tbl[0].t, 1'b1, 5, 12, 4, 1, 0);
    send_beats(tbl[1].r, d, tbl[1].t, 1'b0, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(out_valid), 0);
    end
    run_window("after_midrst", tbl[0].r, d, tbl[0].t, 1'b0, 0, 12, 4, 1, 0);
    send_beats(tbl[0].r, d, tbl[0].t, 1'b0, N);
    chk("outrst_pending", 32'(out_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("outrst_valid", 32'(out_valid), 0);
    check_out("outrst", 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("outrst_no_stale", 32'(out_valid), 0);
    end
    for (int w = 0; w < 60; w++) begin
      for (int i = 0; i < N; i++) begin
        r[i] = $urandom_range(0, 9);
        d[i] = $urandom_range(0, 255);
      end
      t = $urandom_range(0, 15);
      model(r, d, t, ed, er, ex, ee);
      run_window($sformatf("rnd%0d", w), r, d, t, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 ed, er, ex, ee);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
